// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one req/ack bus cycle per aligned
// load/store, stalls the pipeline until it completes, and returns the extended load word.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc;
  logic          ld_op;
  logic [1:0]    ld_size;
  logic          ld_unsigned;
  logic [1:0]    ld_off;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign misalign_exc = (memread | memwrite) &
                        (((ls_size == 2'b01) & addr[0]) | (ls_size[1] & (addr[1:0] != 2'b00)));
  assign acc   = (memread | memwrite) & ~misalign_exc;
  assign stall = ((state == IDLE) & acc) | (state == BUSY);

  // Store lanes are replicated so the memory only needs the byte enables.
  always_comb begin
    st_wdata = wdata;
    st_be    = 4'b1111;
    case (ls_size)
      2'b00: begin
        st_wdata = {4{wdata[7:0]}};
        st_be    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata[15:0]}};
        st_be    = 4'b0011 << addr[1:0];
      end
      default: begin
        st_wdata = wdata;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Lane selection uses the size/offset latched at issue, not the live pipeline inputs.
  assign ld_byte = mem_rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = mem_rdata[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = mem_rdata;
    case (ld_size)
      2'b00:   ld_ext = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      bus_err     <= 1'b0;
      ld_op       <= 1'b0;
      ld_size     <= '0;
      ld_unsigned <= 1'b0;
      ld_off      <= '0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            state       <= BUSY;
            cnt         <= '0;
            mem_req     <= 1'b1;
            mem_we      <= memwrite;
            mem_addr    <= {addr[31:2], 2'b00};
            mem_wdata   <= st_wdata;
            mem_be      <= memwrite ? st_be : 4'b1111;
            ld_op       <= ~memwrite;
            ld_size     <= ls_size;
            ld_unsigned <= ls_unsigned;
            ld_off      <= addr[1:0];
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (ld_op) begin
              load_data  <= ld_ext;
              load_valid <= 1'b1;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            bus_err   <= 1'b1;
            load_data <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; TIMEOUT is shortened to 8 for the timeout case.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [1:0]  ls_size = 2'b00;
  logic        ls_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, stall, load_valid, misalign_exc, bus_err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;

  int total = 0;
  int passed = 0;

  mem_access_unit #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
    .ls_size(ls_size), .ls_unsigned(ls_unsigned), .addr(addr), .wdata(wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .misalign_exc(misalign_exc),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Runs one access already presented on the inputs; ack arrives after wait_n BUSY wait cycles.
  task automatic do_access(input int wait_n, input bit use_ack, input logic [31:0] rd,
                           output int stall_n, output int req_n, output int lv_n,
                           output int err_n, output bit done, output logic [31:0] ld,
                           output logic [31:0] s_addr, output logic [31:0] s_wdata,
                           output logic [3:0] s_be, output logic s_we);
    stall_n = 0; req_n = 0; lv_n = 0; err_n = 0; done = 0; ld = 'x;
    s_addr = 'x; s_wdata = 'x; s_be = 'x; s_we = 1'bx;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ack   = use_ack && (c == wait_n + 1);
      mem_rdata = mem_ack ? rd : 32'hDEAD_BEEF;
      #2;
      if (stall) stall_n++;
      if (mem_req) req_n++;
      if (load_valid) lv_n++;
      if (bus_err) err_n++;
      if (c == 1) begin
        s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be; s_we = mem_we;
      end
      if (c > 0 && !stall) begin
        done = 1;
        ld = load_data;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; memread = 1'b0; memwrite = 1'b0;
    #2;
    if (load_valid) lv_n++;
    if (bus_err) err_n++;
  endtask

  task automatic set_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
    memread = rd; memwrite = wr; ls_size = sz; ls_unsigned = uns; addr = a; wdata = wd;
  endtask

  int stall_n, req_n, lv_n, err_n, cnt_n;
  bit done;
  logic [31:0] ld, s_addr, s_wdata;
  logic [3:0] s_be;
  logic s_we;

  initial begin
    // Reset state
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // 1: lb 0x1003, two wait cycles
    set_op(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0);
    do_access(2, 1, 32'h80FF_1234, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn lb   addr=00001003 stall=%0d req=%0d lv=%0d ld=%h", stall_n, req_n, lv_n, ld);
    chk("lb_done", 32'(done), 32'd1);
    chk("lb_stall_cycles", 32'(stall_n), 32'd4);
    chk("lb_req_cycles", 32'(req_n), 32'd3);
    chk("lb_load_data", ld, 32'hFFFF_FF80);
    chk("lb_load_valid_pulses", 32'(lv_n), 32'd1);
    chk("lb_mem_addr", s_addr, 32'h0000_1000);
    chk("lb_mem_be", 32'(s_be), 32'hF);
    chk("lb_mem_we", 32'(s_we), 32'd0);

    // 2: lhu 0x2002, immediate ack
    set_op(1, 0, 2'b01, 1, 32'h0000_2002, 32'h0);
    do_access(0, 1, 32'hBEEF_0000, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn lhu  addr=00002002 stall=%0d lv=%0d ld=%h", stall_n, lv_n, ld);
    chk("lhu_stall_cycles", 32'(stall_n), 32'd2);
    chk("lhu_load_data", ld, 32'h0000_BEEF);
    chk("lhu_load_valid_pulses", 32'(lv_n), 32'd1);

    // lh, sign-extended lower half
    set_op(1, 0, 2'b01, 0, 32'h0000_2000, 32'h0);
    do_access(1, 1, 32'h1234_8001, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn lh   addr=00002000 stall=%0d ld=%h", stall_n, ld);
    chk("lh_load_data", ld, 32'hFFFF_8001);
    chk("lh_stall_cycles", 32'(stall_n), 32'd3);

    // lbu byte lane 1
    set_op(1, 0, 2'b00, 1, 32'h0000_2101, 32'h0);
    do_access(0, 1, 32'h00C3_A500, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn lbu  addr=00002101 ld=%h", ld);
    chk("lbu_load_data", ld, 32'h0000_00A5);

    // 3: sb 0x3001
    set_op(0, 1, 2'b00, 0, 32'h0000_3001, 32'h0000_00AB);
    do_access(0, 1, 32'h0, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn sb   addr=00003001 be=%b wdata=%h we=%0d lv=%0d", s_be, s_wdata, s_we, lv_n);
    chk("sb_mem_addr", s_addr, 32'h0000_3000);
    chk("sb_mem_be", 32'(s_be), 32'h2);
    chk("sb_mem_wdata", s_wdata, 32'hABAB_ABAB);
    chk("sb_mem_we", 32'(s_we), 32'd1);
    chk("sb_no_load_valid", 32'(lv_n), 32'd0);
    chk("sb_load_data_held", ld, 32'h0000_00A5);

    // sh upper half, two-input (read+write) treated as write
    set_op(1, 1, 2'b01, 0, 32'h0000_3102, 32'h0000_5A6B);
    do_access(0, 1, 32'h0, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn sh   addr=00003102 be=%b wdata=%h we=%0d", s_be, s_wdata, s_we);
    chk("sh_mem_be", 32'(s_be), 32'hC);
    chk("sh_mem_wdata", s_wdata, 32'h5A6B_5A6B);
    chk("sh_mem_we", 32'(s_we), 32'd1);

    // 4: misaligned accesses never reach the bus
    set_op(1, 0, 2'b10, 0, 32'h0000_4002, 32'h0);
    #1;
    chk("lw_misalign_exc", 32'(misalign_exc), 32'd1);
    chk("lw_misalign_stall", 32'(stall), 32'd0);
    cnt_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (mem_req || stall) cnt_n++;
    end
    $display("txn lw   addr=00004002 misalign=%0d req_or_stall_cycles=%0d", misalign_exc, cnt_n);
    chk("lw_misalign_no_bus", 32'(cnt_n), 32'd0);
    set_op(1, 0, 2'b01, 0, 32'h0000_4001, 32'h0);
    #1;
    chk("lh_misalign_exc", 32'(misalign_exc), 32'd1);
    set_op(1, 0, 2'b00, 0, 32'h0000_4001, 32'h0);
    #1;
    chk("lb_odd_not_misaligned", 32'(misalign_exc), 32'd0);
    memread = 1'b0;
    @(posedge clk); #1;

    // 5: lw with no ack times out after 8 BUSY cycles
    set_op(1, 0, 2'b10, 0, 32'h0000_4400, 32'h0);
    do_access(0, 0, 32'h0, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn lw   addr=00004400 timeout req=%0d err=%0d ld=%h", req_n, err_n, ld);
    chk("to_done", 32'(done), 32'd1);
    chk("to_req_cycles", 32'(req_n), 32'd8);
    chk("to_bus_err_pulses", 32'(err_n), 32'd1);
    chk("to_load_data", ld, 32'h0);
    chk("to_no_load_valid", 32'(lv_n), 32'd0);
    #2; chk("to_back_idle_stall", 32'(stall), 32'd0);

    // 6: reset in BUSY
    @(posedge clk); #1;
    set_op(1, 0, 2'b10, 0, 32'h0000_6000, 32'h0);
    load_data_seed: begin
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rb_req_before", 32'(mem_req), 32'd1);
    #1; rst = 1'b1; memread = 1'b0;
    #1;
    chk("rb_req_dropped", 32'(mem_req), 32'd0);
    chk("rb_stall_dropped", 32'(stall), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    cnt_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (load_valid || bus_err || mem_req) cnt_n++;
    end
    $display("txn rst  busy-reset stray_events=%0d", cnt_n);
    chk("rb_no_completion", 32'(cnt_n), 32'd0);
    @(posedge clk); #1;
    set_op(0, 1, 2'b10, 0, 32'h0000_5004, 32'hCAFE_F00D);
    do_access(1, 1, 32'h0, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn sw   addr=00005004 be=%b wdata=%h done=%0d", s_be, s_wdata, done);
    chk("sw_done", 32'(done), 32'd1);
    chk("sw_mem_wdata", s_wdata, 32'hCAFE_F00D);
    chk("sw_mem_be", 32'(s_be), 32'hF);
    chk("sw_mem_addr", s_addr, 32'h0000_5004);
    set_op(1, 0, 2'b10, 0, 32'h0000_5004, 32'h0);
    do_access(0, 1, 32'hCAFE_F00D, stall_n, req_n, lv_n, err_n, done, ld, s_addr, s_wdata, s_be, s_we);
    $display("txn lw   addr=00005004 ld=%h lv=%0d", ld, lv_n);
    chk("lw_after_sw_data", ld, 32'hCAFE_F00D);
    chk("lw_after_sw_valid", 32'(lv_n), 32'd1);
    chk("lw_after_sw_we", 32'(s_we), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
